// File: rtl/run_length_seq.sv
// Multi-cycle leading-run scanner: counts the run of leading bits equal to the
// operand MSB, one C-bit chunk per cycle, stopping at the first chunk that breaks the run.
module run_length_seq #(
    parameter int N = 32,
    parameter int C = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_bits,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          out_bit,
    output logic          out_all,
    output logic          busy
);

    localparam int NC = N / C;
    localparam int LW = $clog2(NC + 1);
    localparam int KW = $clog2(C + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [N-1:0]  sh_r;
    logic          tgt_r;
    logic [CW-1:0] acc_r;
    logic [LW-1:0] left_r;
    logic          all_r;
    logic [C-1:0]  chunk_s;
    logic [KW-1:0] k_s;
    logic          run_s;
    logic          full_s;
    logic          last_s;

    // Leading-match count of the current top chunk against the run polarity.
    always_comb begin
        chunk_s = sh_r[N-1 -: C];
        k_s     = '0;
        run_s   = 1'b1;
        for (int i = C - 1; i >= 0; i--) begin
            if (run_s && (chunk_s[i] == tgt_r)) begin
                k_s = k_s + KW'(1);
            end else begin
                run_s = 1'b0;
            end
        end
    end

    assign full_s = (k_s == KW'(C));
    assign last_s = (left_r == LW'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nx_s = state_r;
        if (flush) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) state_nx_s = SCAN;
                    else          state_nx_s = IDLE;
                end
                SCAN: begin
                    if (!full_s || last_s) state_nx_s = DONE;
                    else                   state_nx_s = SCAN;
                end
                DONE: begin
                    if (out_ready) state_nx_s = IDLE;
                    else           state_nx_s = DONE;
                end
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // Operand capture, chunk shifting and run accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r   <= '0;
            tgt_r  <= 1'b0;
            acc_r  <= '0;
            left_r <= '0;
            all_r  <= 1'b0;
        end else if (!flush) begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sh_r   <= in_bits;
                        tgt_r  <= in_bits[N-1];
                        acc_r  <= '0;
                        left_r <= LW'(NC);
                        all_r  <= 1'b0;
                    end
                end
                SCAN: begin
                    acc_r <= acc_r + CW'(k_s);
                    if (full_s) begin
                        if (last_s) begin
                            all_r <= 1'b1;
                        end else begin
                            sh_r   <= sh_r << C;
                            left_r <= left_r - LW'(1);
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            SCAN: begin
                in_ready = 1'b0;
            end
            DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign out_count = acc_r;
    assign out_bit   = tgt_r;
    assign out_all   = all_r;

endmodule

// File: tb/tb_run_length_seq.sv
// Scoreboard bench for run_length_seq: directed cases plus random operands,
// out_ready back-pressure and flushes, checked against a count-leading-MSB model.
module tb_run_length_seq;

    localparam int N  = 32;
    localparam int C  = 8;
    localparam int NC = N / C;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_bits;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_count;
    logic          out_bit;
    logic          out_all;
    logic          busy;

    always #5 clk = ~clk;

    run_length_seq #(.N(N), .C(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_bit   (out_bit),
        .out_all   (out_all),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] v;
        int          cnt;
        logic        b;
        logic        all;
        int          j;
        int          t0;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;
    bit   stim_done = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk down from the MSB while bits equal it; j is the chunk holding the break.
    function automatic exp_t model(input logic [31:0] v, input int t0);
        exp_t e;
        bit   run;
        e.v   = v;
        e.b   = v[31];
        e.cnt = 0;
        run   = 1'b1;
        for (int i = 31; i >= 0; i--) begin
            if (run && (v[i] == e.b)) e.cnt++;
            else run = 1'b0;
        end
        e.all = (e.cnt == N);
        e.j   = e.all ? NC : (e.cnt / C) + 1;
        e.t0  = t0;
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          len;
        logic        b;
        v   = $urandom;
        len = $urandom_range(1, 32);
        b   = 1'($urandom_range(0, 1));
        for (int i = 0; i < len; i++) v[31-i] = b;
        if (len < 32) v[31-len] = ~b;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every presented result against the queue head, pop on handshake.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_result", 1, 0);
            end else begin
                if (!prev_valid) chk("latency", longint'(cyc - q[0].t0), longint'(q[0].j));
                chk("out_count", longint'(out_count), longint'(q[0].cnt));
                chk("out_bit", longint'(out_bit), longint'(q[0].b));
                chk("out_all", longint'(out_all), longint'(q[0].all));
                if (out_ready) q.delete(0);
            end
        end
        if (rst_n && flush && busy && q.size() > 0) q.delete(0);
        prev_valid = out_valid;
    end

    task automatic issue(input logic [31:0] v);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_bits  = v;
        for (int w = 0; w < 300 && !done; w++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                q.push_back(model(v, cyc + 1));
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bits  = $urandom;
    endtask

    task automatic drain();
        for (int w = 0; w < 300 && q.size() > 0; w++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_pending", longint'(q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_bits   = '0;
        #12;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_count", longint'(out_count), 0);
        chk("rst_out_bit", longint'(out_bit), 0);
        chk("rst_out_all", longint'(out_all), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_busy", longint'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(32'hFFF0_0000);
        drain();

        out_ready = 1'b0;
        issue(32'h4000_0000);
        for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
        chk("hold_reached", longint'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", longint'(in_ready), 0);
            chk("hold_busy", longint'(busy), 1);
            chk("hold_valid", longint'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        issue(32'h0000_0001);
        drain();
        issue(32'hFFFF_FFFF);
        drain();
        issue(32'hFF00_0000);
        drain();

        // Flush in the second SCAN cycle drops the operand.
        issue(32'h0000_0001);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", longint'(in_ready), 1);
        chk("flush_out_valid", longint'(out_valid), 0);
        chk("flush_busy", longint'(busy), 0);
        chk("flush_dropped", longint'(q.size()), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("flush_no_valid", longint'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        issue(32'h8000_0000);
        drain();

        // Asynchronous reset mid-SCAN, after one full chunk has accumulated.
        issue(32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_out_count", longint'(out_count), 0);
        chk("midrst_out_bit", longint'(out_bit), 0);
        chk("midrst_out_all", longint'(out_all), 0);
        chk("midrst_in_ready", longint'(in_ready), 1);
        chk("midrst_busy", longint'(busy), 0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    issue(rand_op());
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #0;
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    flush     = ($urandom_range(0, 31) == 0);
                end
                flush = 1'b0;
            end
        join
        out_ready = 1'b1;
        flush     = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
